instr_queue: RTL and testbench



---
 rtl/instr_queue.sv | 106 ++++++++++
 tb/tb_instr_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: circular FIFO taking up to PUSH_N packets
// per cycle and presenting the POP_N oldest packets combinationally to decode.

module instr_queue_lane #(
  parameter int DATA_WD = 64,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int CW      = 5,
  parameter int LANE    = 0
) (
  input  logic [DEPTH-1:0][DATA_WD-1:0] mem,
  input  logic [AW-1:0]                 head,
  input  logic [CW-1:0]                 count,
  output logic                          valid,
  output logic [DATA_WD-1:0]            data
);
  logic [AW-1:0] idx;

  assign idx   = head + AW'(LANE);
  assign valid = count > CW'(LANE);
  assign data  = valid ? mem[idx] : '0;
endmodule

module instr_queue #(
  parameter  int DATA_WD = 64,
  parameter  int DEPTH   = 16,
  parameter  int PUSH_N  = 4,
  parameter  int POP_N   = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1,
  localparam int PNW     = $clog2(PUSH_N + 1),
  localparam int ONW     = $clog2(POP_N + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push_valid,
  input  logic [PNW-1:0]            push_num,
  input  logic [PUSH_N*DATA_WD-1:0] push_data,
  output logic                      push_ready,
  input  logic [ONW-1:0]            pop_num,
  output logic [POP_N-1:0]          out_valid,
  output logic [POP_N*DATA_WD-1:0]  out_data,
  output logic [CW-1:0]             count,
  output logic                      overflow_err
);
  localparam int CMPW = (CW > PNW) ? CW : PNW;

  logic [DEPTH-1:0][DATA_WD-1:0]  mem;
  logic [PUSH_N-1:0][DATA_WD-1:0] push_lanes;
  logic [POP_N-1:0][DATA_WD-1:0]  lane_data;
  logic [AW-1:0]                  head, tail;
  logic [CW-1:0]                  free, pop_ext, pop_eff, push_cnt;
  logic                           push_acc;

  assign push_lanes = push_data;
  assign out_data   = lane_data;

  // Admission and clamping both use the occupancy registered at cycle start.
  assign free       = CW'(DEPTH) - count;
  assign push_ready = free >= CW'(PUSH_N);
  assign push_acc   = push_valid && (push_num <= PNW'(PUSH_N)) &&
                      (CMPW'(push_num) <= CMPW'(free));
  assign push_cnt   = push_acc ? CW'(push_num) : '0;
  assign pop_ext    = CW'(pop_num);
  assign pop_eff    = (pop_ext > count) ? count : pop_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_valid && !push_acc) overflow_err <= 1'b1;
      tail  <= tail + AW'(push_cnt);
      head  <= head + AW'(pop_eff);
      count <= count + push_cnt - pop_eff;
    end
  end

  // Storage carries no reset; only lanes below push_num land in the ring.
  always_ff @(posedge clk) begin
    if (!flush && push_acc) begin
      for (int i = 0; i < PUSH_N; i++) begin
        if (PNW'(i) < push_num) mem[tail + AW'(i)] <= push_lanes[i];
      end
    end
  end

  for (genvar j = 0; j < POP_N; j++) begin : g_lane
    instr_queue_lane #(
      .DATA_WD(DATA_WD), .DEPTH(DEPTH), .AW(AW), .CW(CW), .LANE(j)
    ) u_lane (
      .mem  (mem),
      .head (head),
      .count(count),
      .valid(out_valid[j]),
      .data (lane_data[j])
    );
  end
endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: queue-based reference model compared every
// cycle, plus hand-computed expectations at the interesting points.

module tb_instr_queue;
  localparam int DW = 64, DEPTH = 16, PUSH_N = 4, POP_N = 2;

  logic         clk = 1'b0, rst = 1'b0, flush = 1'b0, push_valid = 1'b0;
  logic [2:0]   push_num = '0;
  logic [255:0] push_data = '0;
  logic [1:0]   pop_num = '0;
  logic         push_ready, overflow_err;
  logic [1:0]   out_valid;
  logic [127:0] out_data;
  logic [4:0]   count;

  instr_queue #(.DATA_WD(DW), .DEPTH(DEPTH), .PUSH_N(PUSH_N), .POP_N(POP_N)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid),
    .push_num(push_num), .push_data(push_data), .push_ready(push_ready),
    .pop_num(pop_num), .out_valid(out_valid), .out_data(out_data),
    .count(count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int          errors = 0, checks = 0;
  bit          chk_en = 1'b0;
  logic [63:0] mq[$];
  bit          m_ovf = 1'b0;
  logic [63:0] nxt = 64'hC0DE_0001;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: queue semantics straight from the admission/clamp rules.
  task automatic model_upd(input bit pv, input int pn, input logic [255:0] pd,
                           input int popn, input bit fl);
    int sz, fr, pe;
    bit acc;
    sz = mq.size();
    fr = DEPTH - sz;
    pe = (popn < sz) ? popn : sz;
    if (fl) mq.delete();
    else begin
      acc = pv && (pn <= PUSH_N) && (pn <= fr);
      if (pv && !acc) m_ovf = 1'b1;
      repeat (pe) void'(mq.pop_front());
      if (acc) for (int i = 0; i < pn; i++) mq.push_back(pd[i*64 +: 64]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [127:0] eo;
      logic [1:0]   ev;
      eo = '0;
      ev = '0;
      for (int j = 0; j < POP_N; j++)
        if (j < mq.size()) begin ev[j] = 1'b1; eo[j*64 +: 64] = mq[j]; end
      chk("cyc_count", 128'(count), 128'(mq.size()));
      chk("cyc_out_valid", 128'(out_valid), 128'(ev));
      chk("cyc_out_data", out_data, eo);
      chk("cyc_push_ready", 128'(push_ready), 128'((DEPTH - mq.size()) >= PUSH_N));
      chk("cyc_overflow", 128'(overflow_err), 128'(m_ovf));
    end
  end

  task automatic step(input bit pv, input logic [2:0] pn, input logic [255:0] pd,
                      input logic [1:0] popn, input bit fl);
    push_valid = pv; push_num = pn; push_data = pd; pop_num = popn; flush = fl;
    @(posedge clk);
    model_upd(pv, int'(pn), pd, int'(popn), fl);
    #1;
    push_valid = 1'b0; push_num = '0; pop_num = '0; flush = 1'b0;
  endtask

  // Unused lanes carry junk so stray writes would surface later.
  task automatic push_pkts(input int n, input logic [1:0] popn);
    logic [255:0] pd;
    for (int i = 0; i < 4; i++)
      pd[i*64 +: 64] = (i < n) ? nxt + 64'(i) : 64'hBAD0_0000_0000_0000 | 64'(i);
    nxt = nxt + 64'(n);
    step(1'b1, 3'(n), pd, popn, 1'b0);
  endtask

  task automatic async_rst();
    #1 rst = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    #1;
    chk("arst_count", 128'(count), 128'd0);
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_out_data", out_data, 128'd0);
    chk("arst_push_ready", 128'(push_ready), 128'd1);
    #1 rst = 1'b0;
  endtask

  logic [255:0] junk = {4{64'hEEEE_EEEE_EEEE_EEEE}};
  logic [255:0] abcd = {64'hDDDD_0004, 64'hCCCC_0003, 64'hBBBB_0002, 64'hAAAA_0001};

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_push_ready", 128'(push_ready), 128'd1);
    chk("rst_overflow", 128'(overflow_err), 128'd0);

    // Fill to full in four bursts.
    for (int k = 1; k <= 4; k++) begin
      push_pkts(4, 2'd0);
      chk("fill_count", 128'(count), 128'(4 * k));
      chk("fill_push_ready", 128'(push_ready), 128'(k < 4));
    end
    chk("fill_out_valid", 128'(out_valid), 128'b11);
    chk("fill_lane0", 128'(out_data[63:0]), 128'h0000_0000_C0DE_0001);
    chk("fill_lane1", 128'(out_data[127:64]), 128'h0000_0000_C0DE_0002);

    // Push into full queue while popping: rejected, pop still happens.
    step(1'b1, 3'd1, junk, 2'd2, 1'b0);
    chk("full_count", 128'(count), 128'd14);
    chk("full_overflow", 128'(overflow_err), 128'd1);
    chk("full_lane0", 128'(out_data[63:0]), 128'h0000_0000_C0DE_0003);

    // push_ready low but 2 still fit.
    chk("free2_push_ready", 128'(push_ready), 128'd0);
    push_pkts(2, 2'd0);
    chk("free2_count", 128'(count), 128'd16);

    repeat (7) step(1'b0, 3'd0, junk, 2'd2, 1'b0);
    step(1'b0, 3'd0, junk, 2'd1, 1'b0);
    chk("last_count", 128'(count), 128'd1);
    chk("last_out_valid", 128'(out_valid), 128'b01);
    chk("last_lane0", 128'(out_data[63:0]), 128'h0000_0000_C0DE_0012);
    step(1'b0, 3'd0, junk, 2'd2, 1'b0);
    chk("overpop_count", 128'(count), 128'd0);
    chk("overpop_out_data", out_data, 128'd0);

    // Flush beats simultaneous push and pop.
    push_pkts(4, 2'd0); push_pkts(4, 2'd0); push_pkts(2, 2'd0);
    chk("preflush_count", 128'(count), 128'd10);
    step(1'b1, 3'd3, junk, 2'd2, 1'b1);
    chk("flush_count", 128'(count), 128'd0);
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    chk("flush_overflow_kept", 128'(overflow_err), 128'd1);

    // Wrap: bring head=tail=14 with an empty queue.
    async_rst();
    push_pkts(4, 2'd0); push_pkts(4, 2'd0); push_pkts(4, 2'd0); push_pkts(2, 2'd0);
    repeat (7) step(1'b0, 3'd0, junk, 2'd2, 1'b0);
    chk("wrap_empty", 128'(count), 128'd0);
    step(1'b1, 3'd4, abcd, 2'd2, 1'b0);
    chk("wrap_count", 128'(count), 128'd4);
    chk("wrap_lanes_ab", out_data, {64'hBBBB_0002, 64'hAAAA_0001});
    step(1'b0, 3'd0, junk, 2'd2, 1'b0);
    chk("wrap_lanes_cd", out_data, {64'hDDDD_0004, 64'hCCCC_0003});
    chk("wrap_count2", 128'(count), 128'd2);

    // Asynchronous reset mid-cycle at count 7.
    push_pkts(4, 2'd0); push_pkts(1, 2'd0);
    chk("prearst_count", 128'(count), 128'd7);
    async_rst();
    push_pkts(2, 2'd0);
    chk("postarst_count", 128'(count), 128'd2);

    // push_num above PUSH_N is rejected.
    step(1'b1, 3'd5, junk, 2'd0, 1'b0);
    chk("bignum_count", 128'(count), 128'd2);
    chk("bignum_overflow", 128'(overflow_err), 128'd1);

    step(1'b0, 3'd0, junk, 2'd0, 1'b0);
    @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
